// File: rtl/slack_dual_update.sv
// slack_dual_update: box-projects primal+dual into new slack and updates the dual, input bank then state bank.
// Optional macro SLACK_RESIDUAL_EN adds the infinity-norm primal residual on prim_res.
module slack_dual_update #(
    parameter int NX = 12,
    parameter int NU = 4,
    parameter int HORIZON = 30,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int RD_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [31:0]                active_horizon,
    input  logic [NU*DATA_WIDTH-1:0]   u_min,
    input  logic [NU*DATA_WIDTH-1:0]   u_max,
    input  logic [NX*DATA_WIDTH-1:0]   x_min,
    input  logic [NX*DATA_WIDTH-1:0]   x_max,
    output logic                       bank_sel,
    output logic [ADDR_WIDTH-1:0]      rd_address,
    input  logic [DATA_WIDTH-1:0]      p_data_out,
    input  logic [DATA_WIDTH-1:0]      d_data_out,
    input  logic [DATA_WIDTH-1:0]      s_data_out,
    output logic [ADDR_WIDTH-1:0]      wr_address,
    output logic                       s_wren,
    output logic                       d_wren,
    output logic                       sprev_wren,
    output logic [DATA_WIDTH-1:0]      s_data_in,
    output logic [DATA_WIDTH-1:0]      d_data_in,
    output logic [DATA_WIDTH-1:0]      sprev_data_in,
    output logic                       busy,
    output logic                       done,
    output logic [DATA_WIDTH-1:0]      prim_res
);
    localparam int DW = DATA_WIDTH;
    localparam int L = RD_LATENCY;
    localparam int JW = $clog2(NX > NU ? NX : NU);
    localparam logic [JW-1:0] JU = JW'(NU - 1);
    localparam logic [JW-1:0] JX = JW'(NX - 1);
    localparam logic signed [DW+1:0] DMAX = $signed({3'b000, {(DW-1){1'b1}}});
    localparam logic signed [DW+1:0] DMIN = $signed({3'b111, {(DW-1){1'b0}}});

    typedef enum logic [2:0] {IDLE, ISSUE_U, DRAIN_U, ISSUE_X, DRAIN_X, DONE_ST} state_t;
    state_t state, state_n;

    logic [ADDR_WIDTH-1:0] cnt, e_u, e_x;
    logic [JW-1:0] j;
    logic [2:0] drain;
    logic [31:0] nh;
    logic issue, last_issue, last_drain, wren;
    logic [L-1:0] vp;
    logic [ADDR_WIDTH-1:0] ap [L];
    logic [JW-1:0] jp [L];
    logic [JW-1:0] jq;
    logic [DW-1:0] lo_w, hi_w, s_new, d_new;
    logic signed [DW:0] pe, de, lo, hi, t, s_e;
    logic signed [DW+1:0] dn;

    always_comb begin
        nh = active_horizon < 32'd2 ? 32'd2 : active_horizon > 32'(HORIZON) ? 32'(HORIZON) : active_horizon;
        issue = state == ISSUE_U || state == ISSUE_X;
        last_issue = cnt == (state == ISSUE_X ? e_x : e_u) - ADDR_WIDTH'(1);
        last_drain = drain == 3'(L);
        state_n = state;
        case (state)
            IDLE:    state_n = start ? ISSUE_U : IDLE;
            ISSUE_U: state_n = last_issue ? DRAIN_U : ISSUE_U;
            DRAIN_U: state_n = last_drain ? ISSUE_X : DRAIN_U;
            ISSUE_X: state_n = last_issue ? DRAIN_X : ISSUE_X;
            DRAIN_X: state_n = last_drain ? DONE_ST : DRAIN_X;
            default: state_n = IDLE;
        endcase
    end

    assign busy = state != IDLE;
    assign done = state == DONE_ST;
    // Drain states keep their bank so in-flight elements finish against the same memories.
    assign bank_sel = state == ISSUE_X || state == DRAIN_X;
    assign rd_address = cnt;
    assign s_wren = wren;
    assign d_wren = wren;
    assign sprev_wren = wren;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            j <= '0;
            drain <= '0;
            e_u <= '0;
            e_x <= '0;
            vp <= '0;
        end else begin
            state <= state_n;
            cnt <= issue && !last_issue ? cnt + ADDR_WIDTH'(1) : '0;
            j <= issue && !last_issue && j != (state == ISSUE_X ? JX : JU) ? j + JW'(1) : '0;
            drain <= (state == DRAIN_U || state == DRAIN_X) && !last_drain ? drain + 3'd1 : '0;
            if (state == IDLE && start) begin
                e_u <= ADDR_WIDTH'(32'(NU) * (nh - 32'd1));
                e_x <= ADDR_WIDTH'(32'(NX) * nh);
            end
            vp[0] <= issue;
            for (int i = 1; i < L; i++) vp[i] <= vp[i-1];
        end
    end

    always_ff @(posedge clk) begin
        ap[0] <= cnt;
        jp[0] <= j;
        for (int i = 1; i < L; i++) begin
            ap[i] <= ap[i-1];
            jp[i] <= jp[i-1];
        end
    end

    always_comb begin
        jq = jp[L-1];
        lo_w = bank_sel ? x_min[DW*int'(jq) +: DW] : u_min[DW*int'(jq) +: DW];
        hi_w = bank_sel ? x_max[DW*int'(jq) +: DW] : u_max[DW*int'(jq) +: DW];
        pe = $signed({p_data_out[DW-1], p_data_out});
        de = $signed({d_data_out[DW-1], d_data_out});
        lo = $signed({lo_w[DW-1], lo_w});
        hi = $signed({hi_w[DW-1], hi_w});
        t = pe + de;
        // Lower bound is tested first so an inverted box projects to lo.
        s_e = t < lo ? lo : (t > hi ? hi : t);
        s_new = s_e[DW-1:0];
        dn = $signed({de[DW], de}) + $signed({pe[DW], pe}) - $signed({s_e[DW], s_e});
        d_new = dn > DMAX ? DMAX[DW-1:0] : (dn < DMIN ? DMIN[DW-1:0] : dn[DW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wren <= 1'b0;
            wr_address <= '0;
            s_data_in <= '0;
            d_data_in <= '0;
            sprev_data_in <= '0;
        end else begin
            wren <= vp[L-1];
            if (vp[L-1]) begin
                wr_address <= ap[L-1];
                s_data_in <= s_new;
                d_data_in <= d_new;
                sprev_data_in <= s_data_out;
            end
        end
    end

`ifdef SLACK_RESIDUAL_EN
    logic signed [DW:0] r;
    logic [DW:0] ra;
    logic [DW-1:0] res;

    always_comb begin
        r = pe - s_e;
        ra = r[DW] ? $unsigned(-r) : $unsigned(r);
        res = ra[DW] ? '1 : ra[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) prim_res <= '0;
        else if (vp[L-1] && res > prim_res) prim_res <= res;
    end
`else
    assign prim_res = '0;
`endif
endmodule

// File: tb/tb_slack_dual_update.sv
// tb_slack_dual_update: directed runs of slack_dual_update against a latency-2 memory model.
module tb_slack_dual_update;
    logic clk = 0, rst = 1, start = 0;
    logic [31:0] active_horizon = 3;
    logic [63:0] u_min, u_max;
    logic [191:0] x_min, x_max;
    logic bank_sel, s_wren, d_wren, sprev_wren, busy, done;
    logic [8:0] rd_address, wr_address;
    logic [15:0] p_data_out, d_data_out, s_data_out, s_data_in, d_data_in, sprev_data_in, prim_res;

    int pu[512], du[512], su[512], px[512], dx[512], sx[512];
    logic [8:0] ad [2];
    logic bd [2];
    int errors = 0, checks = 0;
    int nx_u, nx_x, n_u, n_x, wr_err, res_exp;
    int last_s_u, last_d_u, last_s_x, last_d_x;
    int ma, mp, md, mlo, mhi, mt, ms, mdn, mr;
    int w0;

    slack_dual_update dut (
        .clk(clk), .rst(rst), .start(start), .active_horizon(active_horizon),
        .u_min(u_min), .u_max(u_max), .x_min(x_min), .x_max(x_max),
        .bank_sel(bank_sel), .rd_address(rd_address),
        .p_data_out(p_data_out), .d_data_out(d_data_out), .s_data_out(s_data_out),
        .wr_address(wr_address), .s_wren(s_wren), .d_wren(d_wren), .sprev_wren(sprev_wren),
        .s_data_in(s_data_in), .d_data_in(d_data_in), .sprev_data_in(sprev_data_in),
        .busy(busy), .done(done), .prim_res(prim_res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ad[0] <= rd_address;
        ad[1] <= ad[0];
        bd[0] <= bank_sel;
        bd[1] <= bd[0];
    end
    assign p_data_out = bd[1] ? 16'(px[ad[1]]) : 16'(pu[ad[1]]);
    assign d_data_out = bd[1] ? 16'(dx[ad[1]]) : 16'(du[ad[1]]);
    assign s_data_out = bd[1] ? 16'(sx[ad[1]]) : 16'(su[ad[1]]);

    // Write monitor: address order, enable pairing and a reference projection per element.
    always @(negedge clk) begin
        if (s_wren || d_wren || sprev_wren) begin
            ma = int'(wr_address);
            if (!(s_wren && d_wren && sprev_wren)) wr_err++;
            if (bank_sel) begin
                if (ma != nx_x) wr_err++;
                nx_x++; n_x++;
                mp = px[ma]; md = dx[ma];
                mlo = int'($signed(x_min[16*(ma%12) +: 16]));
                mhi = int'($signed(x_max[16*(ma%12) +: 16]));
                if (int'($signed(sprev_data_in)) != sx[ma]) wr_err++;
            end else begin
                if (ma != nx_u) wr_err++;
                nx_u++; n_u++;
                mp = pu[ma]; md = du[ma];
                mlo = int'($signed(u_min[16*(ma%4) +: 16]));
                mhi = int'($signed(u_max[16*(ma%4) +: 16]));
                if (int'($signed(sprev_data_in)) != su[ma]) wr_err++;
            end
            mt = mp + md;
            ms = mt < mlo ? mlo : (mt > mhi ? mhi : mt);
            mdn = md + mp - ms;
            mdn = mdn > 32767 ? 32767 : (mdn < -32768 ? -32768 : mdn);
            mr = mp > ms ? mp - ms : ms - mp;
            mr = mr > 65535 ? 65535 : mr;
            if (mr > res_exp) res_exp = mr;
            if (int'($signed(s_data_in)) != ms || int'($signed(d_data_in)) != mdn) wr_err++;
            if (bank_sel) begin last_s_x = int'($signed(s_data_in)); last_d_x = int'($signed(d_data_in)); end
            else begin last_s_u = int'($signed(s_data_in)); last_d_u = int'($signed(d_data_in)); end
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input bit x, input int p, input int d);
        for (int a = 0; a < 512; a++)
            if (x) begin px[a] = p; dx[a] = d; end
            else begin pu[a] = p; du[a] = d; end
    endtask

    task automatic bounds(input bit x, input int lo, input int hi);
        if (x) for (int i = 0; i < 12; i++) begin x_min[16*i +: 16] = 16'(lo); x_max[16*i +: 16] = 16'(hi); end
        else for (int i = 0; i < 4; i++) begin u_min[16*i +: 16] = 16'(lo); u_max[16*i +: 16] = 16'(hi); end
    endtask

    task automatic run(input string tag, input logic [31:0] ah, input int enu, input int enx,
                       input int ecyc, input bit mid);
        int cyc;
        nx_u = 0; nx_x = 0; n_u = 0; n_x = 0; wr_err = 0; res_exp = 0;
        active_horizon = ah;
        start = 1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            start = 0;
            cyc++;
            if (mid && (cyc == 3 || cyc == enu + 5)) start = 1;
        end while (!done && cyc < 1000);
        chk({tag, " done cycle"}, cyc, ecyc);
        chk({tag, " busy at done"}, 32'(busy), 1);
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, 32'(done), 0);
        chk({tag, " idle after done"}, 32'(busy), 0);
        chk({tag, " input writes"}, n_u, enu);
        chk({tag, " state writes"}, n_x, enx);
        chk({tag, " write errors"}, wr_err, 0);
    endtask

    function automatic int rexp(input int v);
`ifdef SLACK_RESIDUAL_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    initial begin
        for (int a = 0; a < 512; a++) begin su[a] = a * 3 - 100; sx[a] = 200 - a; end
        fill(0, 0, 0); fill(1, 0, 0);
        bounds(0, -256, 256); bounds(1, -256, 256);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset wren", 32'({s_wren, d_wren, sprev_wren}), 0);
        chk("reset bank_sel", 32'(bank_sel), 0);
        chk("reset rd_address", 32'(rd_address), 0);
        chk("reset wr_address", 32'(wr_address), 0);
        chk("reset prim_res", 32'(prim_res), 0);

        run("zeros", 3, 8, 36, 51, 0);
        chk("zeros prim_res", 32'(prim_res), 0);

        fill(0, 200, 100);
        run("clip hi", 3, 8, 36, 51, 1);
        chk("clip hi s", last_s_u, 256);
        chk("clip hi d", last_d_u, 44);
        chk("clip hi prim_res", 32'(prim_res), rexp(56));

        fill(0, 0, 0);
        bounds(0, 100, 50); bounds(1, 100, 50);
        run("inverted", 3, 8, 36, 51, 0);
        chk("inverted s u", last_s_u, 100);
        chk("inverted d u", last_d_u, -100);
        chk("inverted s x", last_s_x, 100);
        chk("inverted d x", last_d_x, -100);
        chk("inverted prim_res", 32'(prim_res), rexp(100));

        fill(0, 32767, 32767); fill(1, 32767, 32767);
        bounds(0, -32768, 32767); bounds(1, -32768, -32768);
        run("limits nh2", 0, 4, 24, 35, 0);
        chk("limits s u", last_s_u, 32767);
        chk("limits d u", last_d_u, 32767);
        chk("limits s x", last_s_x, -32768);
        chk("limits d sat", last_d_x, 32767);
        chk("limits prim_res", 32'(prim_res), rexp(65535));

        fill(0, 5, 7); fill(1, 0, 0);
        bounds(0, -256, 256);
        for (int i = 0; i < 12; i++) begin
            x_min[16*i +: 16] = 16'(10 * i - 50);
            x_max[16*i +: 16] = 16'(10 * i - 50);
        end
        run("nh30", 100, 116, 360, 483, 0);
        chk("nh30 s x", last_s_x, 60);
        chk("nh30 d x", last_d_x, -60);
        chk("nh30 s u", last_s_u, 12);
        chk("nh30 prim_res", 32'(prim_res), rexp(60));

        fill(0, 0, 0);
        bounds(0, -256, 256); bounds(1, -256, 256);
        nx_u = 0; nx_x = 0; n_u = 0; n_x = 0; wr_err = 0;
        active_horizon = 3;
        start = 1;
        @(posedge clk); #1 start = 0;
        w0 = 0;
        while (!bank_sel && w0 < 200) begin @(posedge clk); #1; w0++; end
        chk("reach state bank", 32'(bank_sel), 1);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1 rst = 0;
        chk("midrun rst busy", 32'(busy), 0);
        chk("midrun rst wren", 32'({s_wren, d_wren, sprev_wren}), 0);
        chk("midrun rst bank_sel", 32'(bank_sel), 0);
        chk("midrun rst rd_address", 32'(rd_address), 0);
        chk("midrun rst prim_res", 32'(prim_res), 0);
        w0 = n_u + n_x;
        repeat (6) begin @(posedge clk); #1; end
        chk("midrun rst no writes", n_u + n_x, w0);
        chk("midrun rst still idle", 32'(busy), 0);
        run("after rst", 3, 8, 36, 51, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
